// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, constants and helpers for the LEGv8 hazard/forwarding controller
package hazard_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
        logic             set_flags;
    } stage_ctl_t;

    // True when the stage will architecturally write register r (XZR is never written)
    function automatic logic writes(input stage_ctl_t s, input logic [REG_W-1:0] r);
        return s.valid && s.reg_write && (s.rd == r) && (r != ZERO_REG);
    endfunction

    // Forward select for one source: MEM (if not a load) beats WB as the more recent producer
    function automatic fwd_sel_t fwd_sel(input stage_ctl_t mem, input stage_ctl_t wb,
                                         input logic use_r, input logic [REG_W-1:0] r);
        return !use_r                           ? FWD_RF  :
               (writes(mem, r) && !mem.mem_read) ? FWD_MEM :
               writes(wb, r)                     ? FWD_WB  : FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: ID-stage decode fields in, stall/flush/forward controls out
interface hazard_controller_if #(parameter int CNT_W = hazard_pkg::CNT_W);
    import hazard_pkg::*;

    logic             id_valid;
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic             id_use_rn;
    logic             id_use_rm;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_set_flags;
    logic             id_read_flags;
    logic             id_is_cbz;
    logic             id_br_taken;
    logic             stall;
    logic             flush_if;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [1:0]       cbz_fwd;
    logic             flag_fwd;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd, id_reg_write,
               id_mem_read, id_set_flags, id_read_flags, id_is_cbz, id_br_taken,
        input  stall, flush_if, fwd_a, fwd_b, cbz_fwd, flag_fwd, stall_count
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd, id_reg_write,
               id_mem_read, id_set_flags, id_read_flags, id_is_cbz, id_br_taken,
        output stall, flush_if, fwd_a, fwd_b, cbz_fwd, flag_fwd, stall_count
    );

endinterface

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: one shadow pipeline stage of control fields, clearable to a bubble
module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       bubble_i,
    input  stage_ctl_t d_i,
    output stage_ctl_t q_o
);

    stage_ctl_t ctl_q;

    // Advance every cycle; reset or bubble loads an all-zero (invalid) stage
    always_ff @(posedge clk) begin
        ctl_q <= (reset || bubble_i) ? '0 : d_i;
    end

    assign q_o = ctl_q;

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: load-use/CBZ stalls, branch flush and operand/flag forwarding for the 5-stage core
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int CNT_W = hazard_pkg::CNT_W
) (
    input logic          clk,
    input logic          reset,
    hazard_controller_if.slave hz
);

    stage_ctl_t       id_ctl, ex_q, mem_q, wb_q;
    logic [REG_W-1:0] ex_rn_q, ex_rm_q;
    logic             ex_use_rn_q, ex_use_rm_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             load_use, cbz_stall, stall, ex_bubble;
    logic             unused_bits;

    assign id_ctl = '{
        valid:     hz.id_valid,
        rd:        hz.id_rd,
        reg_write: hz.id_reg_write,
        mem_read:  hz.id_mem_read,
        set_flags: hz.id_set_flags
    };

    assign ex_bubble = stall || !hz.id_valid;

    hazard_stage_reg u_ex  (.clk(clk), .reset(reset), .bubble_i(ex_bubble), .d_i(id_ctl), .q_o(ex_q));
    hazard_stage_reg u_mem (.clk(clk), .reset(reset), .bubble_i(1'b0),      .d_i(ex_q),   .q_o(mem_q));
    hazard_stage_reg u_wb  (.clk(clk), .reset(reset), .bubble_i(1'b0),      .d_i(mem_q),  .q_o(wb_q));

    // EX-only source fields, bubbled together with the EX control shadow
    always_ff @(posedge clk) begin
        if (reset || ex_bubble) begin
            ex_rn_q     <= '0;
            ex_rm_q     <= '0;
            ex_use_rn_q <= 1'b0;
            ex_use_rm_q <= 1'b0;
        end else begin
            ex_rn_q     <= hz.id_rn;
            ex_rm_q     <= hz.id_rm;
            ex_use_rn_q <= hz.id_use_rn;
            ex_use_rm_q <= hz.id_use_rm;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        count_q <= reset ? '0 : count_d;
    end

    // Stall detection: loads in EX block any reader; CBZ compares in ID so it also waits on EX ALU ops and MEM loads
    always_comb begin
        load_use  = ex_q.mem_read &&
                    ((hz.id_use_rn && writes(ex_q, hz.id_rn)) || (hz.id_use_rm && writes(ex_q, hz.id_rm)));
        cbz_stall = hz.id_is_cbz &&
                    (writes(ex_q, hz.id_rm) || (mem_q.mem_read && writes(mem_q, hz.id_rm)));
        stall     = load_use || cbz_stall;
        count_d   = (stall && !(&count_q)) ? count_q + 1'b1 : count_q;
    end

    assign hz.stall       = stall;
    assign hz.flush_if    = hz.id_valid && hz.id_br_taken && !stall;
    assign hz.fwd_a       = fwd_sel(mem_q, wb_q, ex_use_rn_q, ex_rn_q);
    assign hz.fwd_b       = fwd_sel(mem_q, wb_q, ex_use_rm_q, ex_rm_q);
    assign hz.cbz_fwd     = fwd_sel(mem_q, wb_q, 1'b1, hz.id_rm);
    assign hz.flag_fwd    = hz.id_read_flags && ex_q.valid && ex_q.set_flags;
    assign hz.stall_count = count_q;

    assign unused_bits = ^{mem_q.set_flags, wb_q.mem_read, wb_q.set_flags};

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Hazard and forwarding controller for the 5-stage pipelined LEGv8 core (IF/ID/EX/MEM/WB).
- Consumes ID-stage decode fields from the instruction decoder and keeps its own shadow copies of the EX, MEM and WB stage control fields.
- Drives PC/IF-ID stall, ID/EX bubble, IF flush, EX operand forwarding selects, the CBZ operand forward select and the flag-forward select.
- Sits beside the pipeline registers in the CPU top level.

Parameters:
- REG_W, 5, register address width.
- ZERO_REG, 31, XZR index; never a hazard source and never forwarded.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rn  in  REG_W  first source register, decoder Rn.
- id_rm  in  REG_W  second source register, post-Reg2Loc select.
- id_use_rn  in  1  instruction reads id_rn.
- id_use_rm  in  1  instruction reads id_rm.
- id_rd  in  REG_W  destination register.
- id_reg_write  in  1  decoder RegWrite.
- id_mem_read  in  1  decoder DataMemRead (LDUR/LDURB).
- id_set_flags  in  1  decoder CmpMode (ADDS/SUBS).
- id_read_flags  in  1  instruction is B.cond.
- id_is_cbz  in  1  CBZ; its id_rm is compared in ID.
- id_br_taken  in  1  branch resolved taken in ID.
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- flush_if  out  1  squash the IF/ID instruction.
- fwd_a  out  2  EX operand A select: 00 regfile, 01 EX/MEM result, 10 MEM/WB value.
- fwd_b  out  2  EX operand B select, same encoding.
- cbz_fwd  out  2  CBZ operand select in ID, same encoding.
- flag_fwd  out  1  1 = B.cond uses live EX ALU flags; 0 = flag register.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Shadow stages EX, MEM and WB each hold: valid, rd, reg_write, mem_read, set_flags. EX additionally holds rn, rm, use_rn, use_rm.
- Shadows advance every cycle: ID→EX, EX→MEM, MEM→WB.
- When stall=1, EX loads a bubble (all fields 0). MEM and WB still advance.
- ID→EX captures the fields only when id_valid=1; otherwise it captures a bubble.
- Stage "writes r" means: valid & reg_write & rd==r & r!=ZERO_REG.
- Load-use stall (combinational): ID uses rn or rm, and EX is a load that writes that register → stall=1.
- CBZ stall:
  - id_is_cbz, and EX writes id_rm (any writer) → stall=1.
  - id_is_cbz, and MEM is a load that writes id_rm → stall=1.
  - Consequence: CBZ after a load stalls 2 cycles; CBZ after an ALU op stalls 1 cycle.
- flush_if = id_valid & id_br_taken & ~stall. While stalling, the branch is unresolved and no flush occurs.
- fwd_a/fwd_b (combinational from shadows), for each used EX source:
  - If MEM writes it and MEM is not a load → 01.
  - Else if WB writes it → 10.
  - Else → 00.
  - MEM has priority over WB (most recent producer).
  - An unused source → 00.
- cbz_fwd (in ID): MEM writes id_rm and is not a load → 01; else WB writes it → 10; else 00. It is don't-care while stall=1 but must still equal a legal encoding.
- flag_fwd = id_read_flags & EX.valid & EX.set_flags. No flag stall is ever raised.
- stall_count: increments on each clk edge with stall=1; holds at all-ones (no wrap).
- All stall/flush/fwd outputs are combinational functions of the registered shadows and the ID inputs. Zero latency.
- Reset: all shadows become bubbles and stall_count=0. The next cycle's outputs are therefore stall=0, flush_if=0, fwd_a=fwd_b=cbz_fwd=00, flag_fwd=0.
- Reset mid-stall: stall drops to 0 in the cycle after reset unless id_* inputs re-create a hazard against the now-empty EX stage. That cannot happen, so stall=0 is guaranteed.
- A source or destination equal to ZERO_REG never stalls and never forwards.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - stage_ctl_t struct {valid, rd, reg_write, mem_read, set_flags}.
  - ZERO_REG constant.
- One sub-module, hazard_stage_reg: a synchronous register of stage_ctl_t with reset and bubble inputs. It is instantiated three times for EX, MEM and WB.

Test Plan:
- LDUR X1 then ADDS X2,X1,X3 → stall=1 for exactly 1 cycle, stall_count=1; next cycle fwd_a=10 (WB).
- ADDS X1 then SUBS X4,X1,X1 → stall=0, fwd_a=fwd_b=01. Same sequence with an independent instruction in between → fwd_a=fwd_b=10.
- LDUR X5 then CBZ X5 → stall=1 for 2 cycles; then with id_br_taken=1 → flush_if=1 for 1 cycle, cbz_fwd=10.
- SUBS then B.LT taken → flag_fwd=1, stall=0, flush_if=1.
- Writer and reader both on X31, including a load → stall=0 and all fwd=00. With stall held for 70000 cycles → stall_count saturates at 16'hFFFF.
- Assert reset during an active load-use stall → next cycle stall=0, all fwd=00, stall_count=0.
